// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multicycle qtcore control unit with memory handshake, bus timeout, single-step and scan
// Optional retire counter output is enabled by defining QTCORE_RETIRE_COUNTER_EN.
module control_unit_mc #(
    parameter int PC_W         = 5,
    parameter int WAIT_TIMEOUT = 15,
    parameter int STATE_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       processor_enable,
    input  logic [7:0] instruction,
    input  logic       ZF,
    input  logic       mem_ready,
    input  logic       step_mode,
    input  logic       step,
    output logic       mem_req,
    output logic       PC_write_enable,
    output logic [1:0] PC_mux_select,
    output logic       ACC_write_enable,
    output logic [1:0] ACC_mux_select,
    output logic       IR_load_enable,
    output logic [3:0] ALU_opcode,
    output logic       ALU_inputB_mux_select,
    output logic       Memory_write_enable,
    output logic [1:0] Memory_address_mux_select,
    output logic       processor_halted,
    output logic       bus_fault,
    input  logic       scan_enable,
    input  logic       scan_in,
    output logic       scan_out
`ifdef QTCORE_RETIRE_COUNTER_EN
    ,
    output logic [15:0] retired_count
`endif
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET = 3'b000,
        S_FETCH = 3'b001,
        S_EXEC  = 3'b010,
        S_PAUSE = 3'b011,
        S_HALT  = 3'b100
    } state_t;

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(WAIT_TIMEOUT);

    generate
        if (PC_W < 3 || PC_W > 16) begin : g_bad_pc_w
            $error("control_unit_mc: PC_W must be within 3..16");
        end
    endgenerate

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   cnt_plus;
    logic             limit_next;
    logic             fault_set;
    logic             retire;

    logic is_mem_op, is_sta, is_ldar, is_load;

    assign is_ldar   = (instruction == 8'hFB);
    assign is_sta    = (instruction[7:5] == 3'b001);
    assign is_load   = (instruction[7:5] == 3'b000) || is_ldar;
    assign is_mem_op = (instruction[7:5] != 3'b111) || is_ldar;

    // The limit is hit in the cycle whose wait would bring the counter to WAIT_TIMEOUT.
    assign cnt_plus   = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
    assign limit_next = (WAIT_TIMEOUT != 0) && (cnt_plus == LIMIT);

    assign scan_out         = state[STATE_W-1];
    assign processor_halted = (state == S_HALT);

    always_comb begin
        ALU_opcode = 4'b1111;
        casez (instruction)
            8'b010?????, 8'b1110????: ALU_opcode = 4'b0000;
            8'b011?????:              ALU_opcode = 4'b0001;
            8'b100?????:              ALU_opcode = 4'b0010;
            8'b101?????:              ALU_opcode = 4'b0011;
            8'b110?????:              ALU_opcode = 4'b0100;
            8'hF6:                    ALU_opcode = 4'b0101;
            8'hF7:                    ALU_opcode = 4'b0110;
            8'hF8:                    ALU_opcode = 4'b0111;
            8'hF9:                    ALU_opcode = 4'b1000;
            8'hFA:                    ALU_opcode = 4'b1001;
            8'hFC:                    ALU_opcode = 4'b1010;
            8'hFD:                    ALU_opcode = 4'b1011;
            8'hFE:                    ALU_opcode = 4'b1100;
            default:                  ALU_opcode = 4'b1111;
        endcase
    end

    always_comb begin
        state_next                = state;
        mem_req                   = 1'b0;
        PC_write_enable           = 1'b0;
        PC_mux_select             = 2'b00;
        ACC_write_enable          = 1'b0;
        ACC_mux_select            = 2'b00;
        IR_load_enable            = 1'b0;
        ALU_inputB_mux_select     = 1'b0;
        Memory_write_enable       = 1'b0;
        Memory_address_mux_select = 2'b00;
        fault_set                 = 1'b0;
        retire                    = 1'b0;

        if (processor_enable) begin
            case (state)
                S_RESET: state_next = S_FETCH;
                S_FETCH: begin
                    mem_req                   = 1'b1;
                    Memory_address_mux_select = 2'b10;
                    if (mem_ready) begin
                        IR_load_enable  = 1'b1;
                        PC_write_enable = 1'b1;
                        state_next      = (instruction == 8'hFF) ? S_HALT : S_EXEC;
                    end else if (limit_next) begin
                        fault_set  = 1'b1;
                        state_next = S_HALT;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        mem_req                   = 1'b1;
                        Memory_address_mux_select = is_ldar ? 2'b01 : 2'b00;
                        if (mem_ready) begin
                            ACC_write_enable    = !is_sta;
                            ACC_mux_select      = is_load ? 2'b01 : 2'b00;
                            Memory_write_enable = is_sta;
                            retire              = 1'b1;
                        end else if (limit_next) begin
                            fault_set  = 1'b1;
                            state_next = S_HALT;
                        end
                    end else begin
                        retire = 1'b1;
                        casez (instruction)
                            8'b1110????: begin
                                ACC_write_enable      = 1'b1;
                                ALU_inputB_mux_select = 1'b1;
                            end
                            8'hF0: begin
                                PC_write_enable = 1'b1;
                                PC_mux_select   = 2'b01;
                            end
                            8'hF1: begin
                                PC_write_enable  = 1'b1;
                                PC_mux_select    = 2'b01;
                                ACC_write_enable = 1'b1;
                                ACC_mux_select   = 2'b10;
                            end
                            8'hF2: begin
                                PC_write_enable = ZF;
                                PC_mux_select   = ZF ? 2'b11 : 2'b00;
                            end
                            8'hF3: begin
                                PC_write_enable = ZF;
                                PC_mux_select   = ZF ? 2'b10 : 2'b00;
                            end
                            8'hF4: begin
                                PC_write_enable = !ZF;
                                PC_mux_select   = !ZF ? 2'b11 : 2'b00;
                            end
                            8'hF5: begin
                                PC_write_enable = !ZF;
                                PC_mux_select   = !ZF ? 2'b10 : 2'b00;
                            end
                            8'hF6, 8'hF7, 8'hF8, 8'hF9, 8'hFA, 8'hFC, 8'hFD, 8'hFE:
                                ACC_write_enable = 1'b1;
                            default: ;
                        endcase
                    end
                    if (retire)
                        state_next = step_mode ? S_PAUSE : S_FETCH;
                end
                S_PAUSE: begin
                    if (step || !step_mode)
                        state_next = S_FETCH;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RESET;
            wait_cnt  <= '0;
            bus_fault <= 1'b0;
        end else if (scan_enable) begin
            state <= state_t'({scan_in, state[STATE_W-1:1]});
        end else if (processor_enable) begin
            state <= state_next;
            if (fault_set)
                bus_fault <= 1'b1;
            if (mem_req && !mem_ready && (state_next == state)) begin
                if (wait_cnt != '1)
                    wait_cnt <= cnt_plus[CNT_W-1:0];
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef QTCORE_RETIRE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst)
            retired_count <= 16'd0;
        else if (!scan_enable && retire)
            retired_count <= retired_count + 16'd1;
    end
`endif

endmodule
